// File: rtl/nand_rst_sequencer_if.sv
// Handshake bundle between the NAND PHY reset sequencer and its environment.
// The sequencer is the slave side; the controller/testbench drives master.
interface nand_rst_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              idelay_rdy;
  logic [NUM_CH-1:0] soft_rst_req;
  logic [NUM_CH-1:0] soft_rst_ack;
  logic [NUM_CH-1:0] ch_rstn;
  logic [NUM_CH-1:0] ch_ready;
  logic              all_ready;
  logic [1:0]        seq_state;
  logic [7:0]        fault_cnt;

  modport master (
    output idelay_rdy, soft_rst_req,
    input  soft_rst_ack, ch_rstn, ch_ready, all_ready, seq_state, fault_cnt
  );

  modport slave (
    input  idelay_rdy, soft_rst_req,
    output soft_rst_ack, ch_rstn, ch_ready, all_ready, seq_state, fault_cnt
  );
endinterface

// File: rtl/nand_rst_sequencer.sv
// Staggered per-channel reset release for a multi-channel NAND PHY, gated by
// IDELAYCTRL readiness, with per-channel soft resets once the bus is running.
module nand_rst_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int STAGGER_CYC = 16,
  parameter int PWRUP_CYC   = 256,
  parameter int CNT_W       = 16
) (
  input  logic                clk0,
  input  logic                rst_tmp,
  nand_rst_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  generate
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("nand_rst_sequencer: NUM_CH must be 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("nand_rst_sequencer: SYNC_STAGES must be at least 2");
    end
    if (STAGGER_CYC < 1 || longint'(STAGGER_CYC) > CNT_MAX) begin : g_bad_stagger
      $error("nand_rst_sequencer: STAGGER_CYC out of range for CNT_W");
    end
    if (PWRUP_CYC < 1 || longint'(PWRUP_CYC) > CNT_MAX) begin : g_bad_pwrup
      $error("nand_rst_sequencer: PWRUP_CYC out of range for CNT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    STAGGER  = 2'd1,
    POWERUP  = 2'd2,
    RUN      = 2'd3
  } seq_state_t;

  seq_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [7:0]             fault_cnt_reg, fault_cnt_next;
  logic                   all_ready_reg, all_ready_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rdy_s;
  logic                   fault;
  logic                   pwrup_done;
  logic [NUM_CH-1:0]      stagger_rel;
  logic [NUM_CH-1:0]      ch_rstn_vec, ch_ready_vec, ack_vec, ch_ready_next_vec;

  always_ff @(posedge clk0 or posedge rst_tmp) begin
    if (rst_tmp) sync_reg <= '0;
    else         sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.idelay_rdy};
  end
  assign rdy_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk0 or posedge rst_tmp) begin
    if (rst_tmp) begin
      state_reg     <= WAIT_RDY;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      fault_cnt_reg <= '0;
      all_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      fault_cnt_reg <= fault_cnt_next;
      all_ready_reg <= all_ready_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    fault       = 1'b0;
    pwrup_done  = 1'b0;
    stagger_rel = '0;
    case (state_reg)
      WAIT_RDY: begin
        if (rdy_s) begin
          state_next = STAGGER;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      STAGGER: begin
        if (!rdy_s) begin
          fault = 1'b1;
        end else if (cnt_reg == STG_LAST) begin
          stagger_rel = NUM_CH'(1) << idx_reg;
          cnt_next    = '0;
          idx_next    = idx_reg + 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = POWERUP;
            idx_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      POWERUP: begin
        if (!rdy_s) begin
          fault = 1'b1;
        end else if (cnt_reg == PWR_LAST) begin
          pwrup_done = 1'b1;
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (!rdy_s) fault = 1'b1;
      end
      default: state_next = WAIT_RDY;
    endcase
    if (fault) begin
      state_next = WAIT_RDY;
      cnt_next   = '0;
      idx_next   = '0;
    end
  end

  always_comb begin
    fault_cnt_next = fault_cnt_reg;
    if (fault && fault_cnt_reg != 8'hFF) fault_cnt_next = fault_cnt_reg + 8'd1;
  end

  // Rises with ch_ready on POWERUP->RUN, but after a soft reset it trails the ack by one cycle.
  always_comb begin
    all_ready_next = (state_next == RUN) && (&ch_ready_next_vec) &&
                     ((state_reg != RUN) || (&ch_ready_vec));
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             rstn_reg, rstn_next;
      logic             ready_reg, ready_next;
      logic             ack_reg, ack_next;
      logic             busy_reg, busy_next;
      logic             settle_reg, settle_next;
      logic [CNT_W-1:0] scnt_reg, scnt_next;

      always_ff @(posedge clk0 or posedge rst_tmp) begin
        if (rst_tmp) begin
          rstn_reg   <= 1'b0;
          ready_reg  <= 1'b0;
          ack_reg    <= 1'b0;
          busy_reg   <= 1'b0;
          settle_reg <= 1'b0;
          scnt_reg   <= '0;
        end else begin
          rstn_reg   <= rstn_next;
          ready_reg  <= ready_next;
          ack_reg    <= ack_next;
          busy_reg   <= busy_next;
          settle_reg <= settle_next;
          scnt_reg   <= scnt_next;
        end
      end

      // Soft reset: hold phase (rstn low) then settle phase (rstn high, not ready).
      always_comb begin
        rstn_next   = rstn_reg;
        ready_next  = ready_reg;
        ack_next    = 1'b0;
        busy_next   = busy_reg;
        settle_next = settle_reg;
        scnt_next   = scnt_reg;
        if (state_reg == WAIT_RDY || fault) begin
          rstn_next   = 1'b0;
          ready_next  = 1'b0;
          busy_next   = 1'b0;
          settle_next = 1'b0;
          scnt_next   = '0;
        end else begin
          case (state_reg)
            STAGGER: if (stagger_rel[gi]) rstn_next = 1'b1;
            POWERUP: if (pwrup_done) ready_next = 1'b1;
            RUN: begin
              if (!busy_reg) begin
                if (bus.soft_rst_req[gi] && ready_reg) begin
                  rstn_next   = 1'b0;
                  ready_next  = 1'b0;
                  busy_next   = 1'b1;
                  settle_next = 1'b0;
                  scnt_next   = '0;
                end
              end else if (!settle_reg) begin
                if (scnt_reg == STG_LAST) begin
                  rstn_next   = 1'b1;
                  settle_next = 1'b1;
                  scnt_next   = '0;
                end else begin
                  scnt_next = scnt_reg + 1'b1;
                end
              end else if (scnt_reg == PWR_LAST) begin
                ready_next  = 1'b1;
                ack_next    = 1'b1;
                busy_next   = 1'b0;
                settle_next = 1'b0;
                scnt_next   = '0;
              end else begin
                scnt_next = scnt_reg + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      assign ch_rstn_vec[gi]       = rstn_reg;
      assign ch_ready_vec[gi]      = ready_reg;
      assign ack_vec[gi]           = ack_reg;
      assign ch_ready_next_vec[gi] = ready_next;
    end
  endgenerate

  assign bus.ch_rstn      = ch_rstn_vec;
  assign bus.ch_ready     = ch_ready_vec;
  assign bus.soft_rst_ack = ack_vec;
  assign bus.all_ready    = all_ready_reg;
  assign bus.seq_state    = state_reg;
  assign bus.fault_cnt    = fault_cnt_reg;

endmodule

// File: tb/tb_nand_rst_sequencer.sv
// Directed bench for nand_rst_sequencer (4 channels, stagger 16, power-up 256).
// Inputs change and outputs are sampled 1 time unit after each rising clk0 edge.
module tb_nand_rst_sequencer;

  logic clk0;
  logic rst_tmp;
  int   vec_cnt;
  int   err_cnt;
  int   n;
  int   ack_cnt [4];
  logic seen;

  nand_rst_sequencer_if #(.NUM_CH(4)) bus ();

  nand_rst_sequencer #(
    .NUM_CH(4), .SYNC_STAGES(3), .STAGGER_CYC(16), .PWRUP_CYC(256), .CNT_W(16)
  ) dut (
    .clk0    (clk0),
    .rst_tmp (rst_tmp),
    .bus     (bus)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", vec_cnt, tag, obs, exp);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_tmp = 1'b1;
    bus.idelay_rdy   = 1'b0;
    bus.soft_rst_req = 4'b0000;
    tick(3);
    check("rst_rstn",  32'(bus.ch_rstn), 32'h0);
    check("rst_ready", 32'(bus.ch_ready), 32'h0);
    check("rst_all",   32'(bus.all_ready), 32'h0);
    check("rst_ack",   32'(bus.soft_rst_ack), 32'h0);
    check("rst_state", 32'(bus.seq_state), 32'h0);
    check("rst_fault", 32'(bus.fault_cnt), 32'h0);
    rst_tmp = 1'b0;
    tick(5);
    check("wait_state", 32'(bus.seq_state), 32'h0);

    // Start-up: idelay_rdy rises at T
    bus.idelay_rdy = 1'b1;
    tick(3);  check("t1_state_T3", 32'(bus.seq_state), 32'h0);
    tick(1);  check("t1_state_T4", 32'(bus.seq_state), 32'h1);
    tick(15); check("t1_rstn_T19", 32'(bus.ch_rstn), 32'h0);
    tick(1);  check("t1_rstn_T20", 32'(bus.ch_rstn), 32'h1);
    tick(16); check("t1_rstn_T36", 32'(bus.ch_rstn), 32'h3);
    tick(16); check("t1_rstn_T52", 32'(bus.ch_rstn), 32'h7);
    tick(16); check("t1_rstn_T68", 32'(bus.ch_rstn), 32'hF);
    check("t1_state_T68", 32'(bus.seq_state), 32'h2);
    tick(32);
    bus.soft_rst_req = 4'b1111;
    tick(1);
    check("t1_req_ignored_rstn",  32'(bus.ch_rstn), 32'hF);
    check("t1_req_ignored_ready", 32'(bus.ch_ready), 32'h0);
    bus.soft_rst_req = 4'b0000;
    tick(222);
    check("t1_ready_T323", 32'(bus.ch_ready), 32'h0);
    check("t1_state_T323", 32'(bus.seq_state), 32'h2);
    tick(1);
    check("t1_ready_T324", 32'(bus.ch_ready), 32'hF);
    check("t1_all_T324",   32'(bus.all_ready), 32'h1);
    check("t1_state_T324", 32'(bus.seq_state), 32'h3);
    check("t1_ack_T324",   32'(bus.soft_rst_ack), 32'h0);

    // Single soft reset on channel 2, pulsed at S
    bus.soft_rst_req = 4'b0100;
    tick(1);
    bus.soft_rst_req = 4'b0000;
    check("t2_rstn_S1",  32'(bus.ch_rstn), 32'hB);
    check("t2_ready_S1", 32'(bus.ch_ready), 32'hB);
    check("t2_all_S1",   32'(bus.all_ready), 32'h0);
    tick(15); check("t2_rstn_S16", 32'(bus.ch_rstn), 32'hB);
    tick(1);  check("t2_rstn_S17", 32'(bus.ch_rstn), 32'hF);
    check("t2_ready_S17", 32'(bus.ch_ready), 32'hB);
    tick(255);
    check("t2_ready_S272", 32'(bus.ch_ready), 32'hB);
    check("t2_ack_S272",   32'(bus.soft_rst_ack), 32'h0);
    tick(1);
    check("t2_ready_S273", 32'(bus.ch_ready), 32'hF);
    check("t2_ack_S273",   32'(bus.soft_rst_ack), 32'h4);
    check("t2_all_S273",   32'(bus.all_ready), 32'h0);
    tick(1);
    check("t2_ack_S274", 32'(bus.soft_rst_ack), 32'h0);
    check("t2_all_S274", 32'(bus.all_ready), 32'h1);

    // Held request on ch2 plus one-cycle requests on ch0/ch3
    foreach (ack_cnt[k]) ack_cnt[k] = 0;
    bus.soft_rst_req = 4'b1101;
    tick(1);
    check("t3_rstn_1",  32'(bus.ch_rstn), 32'h2);
    check("t3_ready_1", 32'(bus.ch_ready), 32'h2);
    bus.soft_rst_req = 4'b0100;
    for (int i = 2; i <= 273; i++) begin
      tick(1);
      for (int k = 0; k < 4; k++) if (bus.soft_rst_ack[k]) ack_cnt[k]++;
      if (i == 100) begin
        check("t3_rstn_100",  32'(bus.ch_rstn), 32'hF);
        check("t3_ready_100", 32'(bus.ch_ready), 32'h2);
      end
    end
    check("t3_acks_ch0", 32'(ack_cnt[0]), 32'd1);
    check("t3_acks_ch1", 32'(ack_cnt[1]), 32'd0);
    check("t3_acks_ch2", 32'(ack_cnt[2]), 32'd1);
    check("t3_acks_ch3", 32'(ack_cnt[3]), 32'd1);
    check("t3_ready_273", 32'(bus.ch_ready), 32'hF);
    tick(1);
    check("t3_retrig_rstn", 32'(bus.ch_rstn), 32'hB);
    check("t3_retrig_ready", 32'(bus.ch_ready), 32'hB);
    bus.soft_rst_req = 4'b0000;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 300) begin
      tick(1);
      n++;
      if (bus.soft_rst_ack[2]) seen = 1'b1;
    end
    check("t3_second_ack", 32'(seen), 32'h1);
    check("t3_second_ack_lat", 32'(n), 32'd272);
    tick(1);
    check("t3_all_back", 32'(bus.all_ready), 32'h1);

    // Fault during POWERUP
    rst_tmp = 1'b1;
    tick(1);
    rst_tmp = 1'b0;
    tick(100);
    check("t4_state_pre", 32'(bus.seq_state), 32'h2);
    check("t4_fault_pre", 32'(bus.fault_cnt), 32'h0);
    bus.idelay_rdy = 1'b0;
    tick(3);
    check("t4_rstn_D3", 32'(bus.ch_rstn), 32'hF);
    tick(1);
    check("t4_rstn_D4",  32'(bus.ch_rstn), 32'h0);
    check("t4_fault_D4", 32'(bus.fault_cnt), 32'h1);
    check("t4_state_D4", 32'(bus.seq_state), 32'h0);
    tick(1);
    bus.idelay_rdy = 1'b1;
    tick(4);   check("t4_restart", 32'(bus.seq_state), 32'h1);
    tick(319); check("t4_state_T323", 32'(bus.seq_state), 32'h2);
    tick(1);
    check("t4_all_T324",   32'(bus.all_ready), 32'h1);
    check("t4_ready_T324", 32'(bus.ch_ready), 32'hF);
    check("t4_fault_keep", 32'(bus.fault_cnt), 32'h1);

    // Asynchronous reset mid-STAGGER
    bus.idelay_rdy = 1'b0;
    tick(4);
    check("t5_fault2", 32'(bus.fault_cnt), 32'h2);
    tick(1);
    bus.idelay_rdy = 1'b1;
    tick(36);
    check("t5_rstn_T36", 32'(bus.ch_rstn), 32'h3);
    #2;
    rst_tmp = 1'b1;
    #1;
    check("t5_async_rstn",  32'(bus.ch_rstn), 32'h0);
    check("t5_async_fault", 32'(bus.fault_cnt), 32'h0);
    check("t5_async_state", 32'(bus.seq_state), 32'h0);
    tick(1);
    rst_tmp = 1'b0;

    // Repeated drops: saturation of fault_cnt
    for (int i = 0; i < 300; i++) begin
      bus.idelay_rdy = 1'b1;
      n = 0;
      while (bus.seq_state != 2'd1 && n < 10) begin tick(1); n++; end
      check("t6_enter", 32'(bus.seq_state), 32'h1);
      bus.idelay_rdy = 1'b0;
      n = 0;
      while (bus.seq_state != 2'd0 && n < 10) begin tick(1); n++; end
      check("t6_drop", 32'(bus.seq_state), 32'h0);
      if (i == 254) check("t6_cnt_255", 32'(bus.fault_cnt), 32'd255);
    end
    check("t6_saturated", 32'(bus.fault_cnt), 32'd255);
    check("t6_rstn_low",  32'(bus.ch_rstn), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nand_rst_sequencer.md
Name: nand_rst_sequencer

Overview:
- Parametrised reset sequencer for a multi-channel NAND PHY. Runs in the clk0 domain.
- Waits for the IDELAYCTRL ready flag, then releases per-channel active-low resets in a staggered order. This limits simultaneous switching on bus power-up.
- Enforces a power-up settle window before declaring each channel ready.
- After start-up it services per-channel soft-reset requests, and it re-enters reset if IDELAY readiness is lost.

Parameters:
- NUM_CH, 4: number of NAND channels; range 1..16.
- SYNC_STAGES, 3: flop depth of the idelay_rdy synchroniser; at least 2.
- STAGGER_CYC, 16: clk0 cycles between successive channel releases. Also the hold time of a soft reset. At least 1.
- PWRUP_CYC, 256: clk0 cycles from reset release to ready; at least 1.
- CNT_W, 16: counter width. Elaboration fails if STAGGER_CYC or PWRUP_CYC exceeds 2^CNT_W-1.

Ports:
- clk0, in, 1: system clock.
- rst_tmp, in, 1: reset, asynchronous, active-high.
- idelay_rdy, in, 1: IDELAYCTRL RDY. Treated as asynchronous and synchronised internally.
- soft_rst_req, in, NUM_CH: per-channel soft-reset request, sampled at clk0.
- soft_rst_ack, out, NUM_CH: one-cycle pulse when that channel's soft reset completes.
- ch_rstn, out, NUM_CH: per-channel reset, active-low.
- ch_ready, out, NUM_CH: channel out of reset and settled.
- all_ready, out, 1: every channel ready and the FSM is in RUN.
- seq_state, out, 2: encoding 0 = WAIT_RDY, 1 = STAGGER, 2 = POWERUP, 3 = RUN.
- fault_cnt, out, 8: count of idelay_rdy drops, saturating at 255.

Behaviour:
- Reset (rst_tmp high): all outputs take their reset values. ch_rstn=0, ch_ready=0, all_ready=0, soft_rst_ack=0, fault_cnt=0, seq_state=WAIT_RDY. Synchroniser flops clear to 0, and all counters and the channel index clear.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rdy_s is idelay_rdy after SYNC_STAGES flops.
- WAIT_RDY:
  - Outputs held as in reset.
  - When rdy_s=1: go to STAGGER with cnt=0 and idx=0.
- STAGGER:
  - cnt increments each cycle.
  - When cnt==STAGGER_CYC-1: set ch_rstn[idx]=1, clear cnt, increment idx.
  - Channel k is released (k+1)*STAGGER_CYC cycles after STAGGER is entered.
  - The cycle that releases channel NUM_CH-1 also moves the FSM to POWERUP with cnt=0.
- POWERUP:
  - cnt increments each cycle.
  - When cnt==PWRUP_CYC-1: set all ch_ready=1 and go to RUN. all_ready rises on the same edge.
- RUN, soft reset:
  - A channel is idle when ch_ready[i]=1 and no soft reset is in progress on it.
  - If soft_rst_req[i]=1 while channel i is idle: next cycle ch_rstn[i]=0 and ch_ready[i]=0, and the per-channel counter starts.
  - ch_rstn[i] is held low for STAGGER_CYC cycles, then driven high.
  - PWRUP_CYC cycles after release: ch_ready[i]=1 and soft_rst_ack[i] pulses high for exactly one cycle, on the same edge.
  - Requests on a busy channel are ignored (no queueing).
  - Requests outside RUN are ignored and never acked.
  - Simultaneous requests on several channels proceed in parallel and independently (no staggering).
- all_ready: registered value of (state==RUN) and all ch_ready bits set. It drops the cycle after any channel enters soft reset.
- Fault: rdy_s falling to 0 in STAGGER, POWERUP or RUN causes, on the next edge:
  - all ch_rstn=0, ch_ready=0, all_ready=0;
  - all in-progress soft resets aborted with no ack;
  - fault_cnt incremented, saturating at 255;
  - state set to WAIT_RDY.
  - A full restart sequence follows once rdy_s returns to 1.
  - fault_cnt is cleared only by rst_tmp.
- rst_tmp asserted mid-sequence: immediate asynchronous return to the reset values, including fault_cnt.
- NUM_CH=1: STAGGER releases the single channel after STAGGER_CYC cycles, then goes to POWERUP.

Test Plan (NUM_CH=4, STAGGER_CYC=16, PWRUP_CYC=256, SYNC_STAGES=3):
1. Deassert rst_tmp, raise idelay_rdy at cycle T -> seq_state=1 at T+4. ch_rstn goes 0001, 0011, 0111, 1111 at T+20, T+36, T+52, T+68. ch_ready=1111, all_ready=1 and seq_state=3 at T+324.
2. In RUN, pulse soft_rst_req=0100 for 1 cycle at cycle S:
   - ch_rstn[2]=0 and all_ready=0 from S+1;
   - ch_rstn[2]=1 at S+17;
   - ch_ready[2]=1 with a single soft_rst_ack[2] pulse at S+273;
   - all_ready=1 at S+274.
3. Hold soft_rst_req=0100 high throughout -> the reset is re-triggered only after each ack. Requests from other channels at the same time all complete, each with exactly one ack.
4. Drop idelay_rdy for 5 cycles during POWERUP -> all ch_rstn=0 and fault_cnt=1 within 4 cycles of the drop. The sequence restarts and full ready is reached 324 cycles after rdy returns.
5. Assert rst_tmp in the middle of STAGGER with ch_rstn=0011 -> ch_rstn=0000 and fault_cnt=0 immediately, without waiting for a clk0 edge.
6. Apply 300 idelay_rdy drop/restore cycles -> fault_cnt saturates at 255 and does not wrap.
